ex_mem_skid_stage: RTL and testbench
====================================

// Module: ex_mem_skid_stage
// PURPOSE
//  Parametrised EX/MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  The memory stage can stall without a combinational ready path back into EX.
//  Squashes configurable control bits on a memory read+write conflict.
//  Flushes on branch redirect. Keeps saturating performance counters.
//  Sits between the EX stage (upstream) and the MEM stage (downstream) of the MIPS pipeline.
// PARAMETERS
//  DATA_W     64      payload width (ALU result, store data, branch target, dest reg packed)
//  CTRL_W     8       control-bit vector width
//  MEMRD_BIT  3       index of memread in ctrl
//  MEMWR_BIT  2       index of memwrite in ctrl
//  HAZ_MASK   8'h0D   ctrl bits forced to 0 on conflict (regwrite, memread, memwrite)
//  CNT_W      32      counter width
// PORTS
//  clk            in   1       the single clock; all state updates on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  flush          in   1       sync flush (branch taken / exception)
//  clr_counters   in   1       sync clear of all counters
//  in_valid       in   1       EX offers an entry
//  in_ready       out  1       stage can accept; registered
//  in_data        in   DATA_W  payload
//  in_ctrl        in   CTRL_W  control bits
//  out_valid      out  1       entry presented to MEM
//  out_ready      in   1       MEM consumes the entry
//  out_data       out  DATA_W  payload of head entry
//  out_ctrl       out  CTRL_W  control bits of head entry (post-squash)
//  out_hazard     out  1       head entry was squashed
//  status         out  2       occupancy state (pkg encoding)
//  xfer_count     out  CNT_W   output handshakes
//  stall_count    out  CNT_W   cycles with out_valid && !out_ready
//  hazard_count   out  CNT_W   accepted entries that were squashed
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - All valids, data, ctrl, hazard flags and counters are 0.
//   - State is EMPTY and in_ready=0; in_ready becomes 1 on the first clk edge after deassertion.
//  Handshakes:
//   - Accept = in_valid && in_ready.
//   - Pop = out_valid && out_ready.
//   - in_valid/in_data may change freely while in_ready=0; nothing is latched.
//  Storage: head register (drives outputs) plus skid register. Latency is 1 cycle, EMPTY -> out_valid.
//  FSM:
//   - EMPTY: accept -> ONE (fill head).
//   - ONE:   accept && !pop -> FULL (fill skid);
//            pop && !accept -> EMPTY;
//            accept && pop  -> ONE (head reloads from input).
//   - FULL:  pop -> ONE (skid moves to head); in_ready=0 throughout FULL.
//   - in_ready = (state != FULL), registered from next-state. No comb path out_ready -> in_ready.
//  Squash:
//   - Conflict = in_ctrl[MEMRD_BIT] && in_ctrl[MEMWR_BIT] on accept.
//   - Stored ctrl = in_ctrl & ~HAZ_MASK; the entry's hazard flag is set.
//   - The entry is still transferred (stays a bubble-safe slot).
//  Flush:
//   - Highest priority; next edge -> EMPTY, both valids 0.
//   - Any accept or pop in the flush cycle is discarded. A pop in the flush cycle is not counted.
//   - Payload registers need not clear.
//  Counters:
//   - Saturate at all-ones; no wrap.
//   - clr_counters has priority over increments in the same cycle.
//   - stall_count counts every cycle out_valid=1 && out_ready=0, FULL included.
//  status: 00 EMPTY, 01 ONE, 10 FULL, 11 never driven.
//  Data order is strictly FIFO; no entry is duplicated or lost except by flush.
// STRUCTURE
//  pipe_pkg:
//   - stage_state_t enum {EMPTY=2'b00, ONE=2'b01, FULL=2'b10}
//   - default HAZ_MASK constant
//  Sub-module pipe_sat_counter #(CNT_W)
//   - ports: clk, reset_n, clr, inc, count; instantiated three times
// TESTING
//  1. Reset mid-traffic: drop reset_n while FULL -> out_valid=0 immediately, counters 0, in_ready=1 one edge after release.
//  2. Streaming: in_valid=1, out_ready=1, data 1..10 -> out_data 1..10 back-to-back from cycle 1; xfer_count=10, status stays ONE.
//  3. Backpressure: out_ready=0, push 0xA, 0xB -> FULL, in_ready=0, 0xC held off. Release -> outputs A,B,C in order; stall_count equals stalled cycles.
//  4. Conflict: in_ctrl=8'h0F -> out_ctrl=8'h02, out_hazard=1, hazard_count=1. in_ctrl=8'h0B -> passes unchanged.
//  5. Flush while FULL with simultaneous in_valid and out_ready -> next cycle EMPTY, no entry seen, xfer_count unchanged.
//  6. Saturation: CNT_W=4, 20 transfers -> xfer_count=4'hF. clr_counters with a pop the same cycle -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX/MEM skid stage.
package pipe_pkg;

  // Occupancy of the stage; the encoding is visible on the status port.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } stage_state_t;

  // Control bits cleared on a memread+memwrite conflict: regwrite, memwrite, memread.
  localparam logic [7:0] HAZ_MASK_DEFAULT = 8'h0D;

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// Handshake bundle between EX (upstream), the EX/MEM stage and MEM (downstream).
// The slave modport is the stage's view; the master modport is the surrounding pipeline.
interface ex_mem_skid_stage_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_hazard;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_hazard
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_hazard
  );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage's performance statistics.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear beats increment; once all-ones the value sticks until cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: head + skid register pair with a registered in_ready,
// squash of conflicting memory control bits, branch flush and statistics.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 8,
  parameter int                MEMRD_BIT = 3,
  parameter int                MEMWR_BIT = 2,
  parameter logic [CTRL_W-1:0] HAZ_MASK  = CTRL_W'(HAZ_MASK_DEFAULT),
  parameter int                CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 clr_counters,
  ex_mem_skid_stage_if.slave   bus,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     xfer_count,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     hazard_count
);

  stage_state_t      state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic              head_haz_q, skid_haz_q;

  logic              head_valid;
  logic              accept, pop, conflict;
  logic [CTRL_W-1:0] in_ctrl_sq;
  logic              load_head_in, load_head_skid, load_skid;

  assign head_valid = (state_q != EMPTY);
  assign accept     = bus.in_valid && in_ready_q;
  assign pop        = head_valid && bus.out_ready;
  assign conflict   = bus.in_ctrl[MEMRD_BIT] && bus.in_ctrl[MEMWR_BIT];
  assign in_ctrl_sq = conflict ? (bus.in_ctrl & ~HAZ_MASK) : bus.in_ctrl;

  // Next occupancy and which storage registers load; flush overrides any handshake.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Payload storage: head feeds the outputs, skid absorbs the entry that arrives while MEM stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data_q <= '0;
      head_ctrl_q <= '0;
      head_haz_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_haz_q  <= 1'b0;
    end else begin
      if (load_head_in) begin
        head_data_q <= bus.in_data;
        head_ctrl_q <= in_ctrl_sq;
        head_haz_q  <= conflict;
      end else if (load_head_skid) begin
        head_data_q <= skid_data_q;
        head_ctrl_q <= skid_ctrl_q;
        head_haz_q  <= skid_haz_q;
      end
      if (load_skid) begin
        skid_data_q <= bus.in_data;
        skid_ctrl_q <= in_ctrl_sq;
        skid_haz_q  <= conflict;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head_data_q;
  assign bus.out_ctrl   = head_ctrl_q;
  assign bus.out_hazard = head_haz_q;
  assign status         = state_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_counters),
    .inc     (pop && !flush),
    .count   (xfer_count)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_counters),
    .inc     (head_valid && !bus.out_ready),
    .count   (stall_count)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_counters),
    .inc     (accept && conflict && !flush),
    .count   (hazard_count)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed self-checking bench for ex_mem_skid_stage (4-bit counters to reach saturation quickly).
module tb_ex_mem_skid_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             clr_counters;
  logic [1:0]       status;
  logic [CNT_W-1:0] xfer_count;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] hazard_count;

  int checks;
  int errors;

  ex_mem_skid_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  ex_mem_skid_stage #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .clr_counters (clr_counters),
    .bus          (bus),
    .status       (status),
    .xfer_count   (xfer_count),
    .stall_count  (stall_count),
    .hazard_count (hazard_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; clr_counters = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL reset_status: got %b expected 00", status); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if ({xfer_count, stall_count, hazard_count} !== '0) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h/%h expected 0/0/0", xfer_count, stall_count, hazard_count); end
    tick();
    reset_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_in_ready_early: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    clear_counters();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_ctrl = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 64'(i);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'(i)) begin errors++; $display("[TB] FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.out_valid, bus.out_data, 64'(i)); end
      checks++; if (status !== 2'b01) begin errors++; $display("[TB] FAIL stream_status[%0d]: got %b expected 01", i, status); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (xfer_count !== 4'd10) begin errors++; $display("[TB] FAIL stream_xfer: got %0d expected 10", xfer_count); end
    checks++; if (status !== 2'b00 || stall_count !== 4'd0) begin errors++; $display("[TB] FAIL stream_drain: got status=%b stall=%0d expected 00/0", status, stall_count); end
  endtask

  task automatic test_backpressure();
    clear_counters();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_ctrl = 8'h00;
    bus.in_data = 64'hA;
    tick();
    bus.in_data = 64'hB;
    tick();
    checks++; if (status !== 2'b10 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full: got status=%b in_ready=%b expected 10/0", status, bus.in_ready); end
    checks++; if (bus.out_data !== 64'hA) begin errors++; $display("[TB] FAIL bp_head: got %h expected a", bus.out_data); end
    bus.in_data = 64'hC;
    tick();
    tick();
    checks++; if (status !== 2'b10 || bus.out_data !== 64'hA) begin errors++; $display("[TB] FAIL bp_hold: got status=%b d=%h expected 10/a", status, bus.out_data); end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("[TB] FAIL bp_stall: got %0d expected 3", stall_count); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_data !== 64'hB || status !== 2'b01) begin errors++; $display("[TB] FAIL bp_second: got d=%h status=%b expected b/01", bus.out_data, status); end
    tick();
    checks++; if (bus.out_data !== 64'hC || bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third: got d=%h v=%b expected c/1", bus.out_data, bus.out_valid); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (xfer_count !== 4'd3 || stall_count !== 4'd3 || status !== 2'b00) begin errors++; $display("[TB] FAIL bp_totals: got xfer=%0d stall=%0d status=%b expected 3/3/00", xfer_count, stall_count, status); end
  endtask

  task automatic test_conflict();
    clear_counters();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.in_data = 64'h11; bus.in_ctrl = 8'h0F;
    tick();
    checks++; if (bus.out_ctrl !== 8'h02 || bus.out_hazard !== 1'b1) begin errors++; $display("[TB] FAIL conflict_squash: got ctrl=%h haz=%b expected 02/1", bus.out_ctrl, bus.out_hazard); end
    checks++; if (hazard_count !== 4'd1 || bus.out_data !== 64'h11) begin errors++; $display("[TB] FAIL conflict_count: got cnt=%0d d=%h expected 1/11", hazard_count, bus.out_data); end
    bus.in_data = 64'h22; bus.in_ctrl = 8'h0B;
    tick();
    checks++; if (bus.out_ctrl !== 8'h0B || bus.out_hazard !== 1'b0) begin errors++; $display("[TB] FAIL conflict_pass: got ctrl=%h haz=%b expected 0b/0", bus.out_ctrl, bus.out_hazard); end
    checks++; if (hazard_count !== 4'd1) begin errors++; $display("[TB] FAIL conflict_count2: got %0d expected 1", hazard_count); end
    bus.in_valid = 1'b0; bus.in_ctrl = 8'h00;
    tick();
    checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL conflict_drain: got %b expected 00", status); end
  endtask

  task automatic test_flush();
    clear_counters();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 64'h31;
    tick();
    bus.in_data = 64'h32;
    tick();
    checks++; if (status !== 2'b10) begin errors++; $display("[TB] FAIL flush_prefill: got %b expected 10", status); end
    bus.in_data = 64'h33; bus.out_ready = 1'b1; flush = 1'b1;
    tick();
    checks++; if (status !== 2'b00 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty: got status=%b v=%b expected 00/0", status, bus.out_valid); end
    checks++; if (xfer_count !== 4'd0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_xfer: got xfer=%0d in_ready=%b expected 0/1", xfer_count, bus.in_ready); end
    flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || xfer_count !== 4'd0) begin errors++; $display("[TB] FAIL flush_after: got v=%b xfer=%0d expected 0/0", bus.out_valid, xfer_count); end
  endtask

  task automatic test_saturation();
    clear_counters();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.in_data = 64'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (xfer_count !== 4'hF) begin errors++; $display("[TB] FAIL sat_xfer: got %h expected f", xfer_count); end
    bus.in_valid = 1'b1; bus.in_data = 64'h55; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
    checks++; if (xfer_count !== 4'd0 || stall_count !== 4'd0 || status !== 2'b00) begin errors++; $display("[TB] FAIL sat_clear: got xfer=%0d stall=%0d status=%b expected 0/0/00", xfer_count, stall_count, status); end
    tick();
    checks++; if (xfer_count !== 4'd0) begin errors++; $display("[TB] FAIL sat_clear_hold: got %0d expected 0", xfer_count); end
  endtask

  task automatic test_reset_mid_traffic();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 64'h41;
    tick();
    bus.in_data = 64'h42;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (status !== 2'b10 || stall_count !== 4'd2) begin errors++; $display("[TB] FAIL mid_prefill: got status=%b stall=%0d expected 10/2", status, stall_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || status !== 2'b00 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got v=%b status=%b in_ready=%b expected 0/00/0", bus.out_valid, status, bus.in_ready); end
    checks++; if ({xfer_count, stall_count, hazard_count} !== '0) begin errors++; $display("[TB] FAIL mid_reset_counters: got %h/%h/%h expected 0/0/0", xfer_count, stall_count, hazard_count); end
    tick();
    reset_n = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_early: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_release: got in_ready=%b v=%b expected 1/0", bus.in_ready, bus.out_valid); end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_conflict();
    test_flush();
    test_saturation();
    test_reset_mid_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
